debug_key_ctrl: RTL and testbench

//  Controller for the Analogue debug key's button and LED (after the pin-level cart adapter).

---
 rtl/debug_key_ctrl.sv | 114 +++++++++++
 tb/tb_debug_key_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_key_ctrl.sv
// debug_key_ctrl: debounced button event classifier and priority-shared LED driver
// with blink phases and a press-acknowledge flash.
module debug_key_ctrl #(
    parameter int NUM_REQ           = 4,
    parameter int DEBOUNCE_CYCLES   = 742500,
    parameter int LONG_PRESS_CYCLES = 74250000,
    parameter int BLINK_HALF_CYCLES = 18562500,
    parameter int ACK_CYCLES        = 3712500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   button_raw,
    output logic                   led,
    output logic                   button_lvl,
    output logic                   press_pulse,
    output logic                   short_pulse,
    output logic                   long_pulse,
    input  logic [NUM_REQ-1:0]     led_req,
    input  logic [2*NUM_REQ-1:0]   led_mode,
    output logic [NUM_REQ-1:0]     led_grant
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int PW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam int AW = ACK_CYCLES > 0 ? $clog2(ACK_CYCLES + 1) : 1;
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic               s1_q, s2_q, lvl_q, lvl_dly_q;
    logic [DW-1:0]      db_cnt_q, db_cnt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [PW-1:0]      ph_q, ph_d;
    logic [AW-1:0]      ack_q, ack_d;
    logic               long_fired_q, long_fired_d;
    logic               slow_q, slow_d, fast_q, fast_d;
    logic               press_q, short_q, long_q, led_q, led_d, lvl_d;
    logic [NUM_REQ-1:0] grant_q, win_oh;
    logic [IW-1:0]      win_idx;
    logic [2*NUM_REQ-1:0] mode_sh;
    logic [1:0]         win_mode;
    logic               rise, fall, db_same, db_done, long_hit, ph_wrap, any_req;

    always_comb begin
        rise         = lvl_q & ~lvl_dly_q;
        fall         = ~lvl_q & lvl_dly_q;
        db_same      = s2_q == lvl_q;
        db_done      = !db_same && db_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
        db_cnt_d     = (db_same || db_done) ? '0 : db_cnt_q + 1'b1;
        lvl_d        = db_done ? s2_q : lvl_q;
        // the rising-edge cycle is hold count zero, so a stale count never fires long
        long_hit     = lvl_q && !rise && !long_fired_q && hold_q == HW'(LONG_PRESS_CYCLES - 1);
        hold_d       = rise ? '0 : (lvl_q && hold_q != HW'(LONG_PRESS_CYCLES)) ? hold_q + 1'b1 : hold_q;
        long_fired_d = rise ? 1'b0 : long_fired_q | long_hit;
        ack_d        = rise ? AW'(ACK_CYCLES) : ack_q != '0 ? ack_q - 1'b1 : ack_q;
        ph_wrap      = ph_q == PW'(BLINK_HALF_CYCLES - 1);
        ph_d         = ph_wrap ? '0 : ph_q + 1'b1;
        slow_d       = slow_q ^ ph_wrap;
        fast_d       = fast_q ^ (ph_wrap | (ph_q == PW'(BLINK_HALF_CYCLES / 2 - 1)));
        any_req      = |led_req;
        win_idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (led_req[i]) win_idx = IW'(i);
        win_oh       = any_req ? NUM_REQ'(1) << win_idx : '0;
        mode_sh      = led_mode >> {win_idx, 1'b0};
        win_mode     = mode_sh[1:0];
        led_d        = ack_q != '0 ? 1'b1 :
                       !any_req    ? 1'b0 :
                       win_mode[1] ? (win_mode[0] ? fast_q : slow_q) : win_mode[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            db_cnt_q     <= '0;
            lvl_q        <= 1'b0;
            lvl_dly_q    <= 1'b0;
            hold_q       <= '0;
            long_fired_q <= 1'b0;
            press_q      <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
            ack_q        <= '0;
            ph_q         <= '0;
            slow_q       <= 1'b0;
            fast_q       <= 1'b0;
            grant_q      <= '0;
            led_q        <= 1'b0;
        end else begin
            s1_q         <= button_raw;
            s2_q         <= s1_q;
            db_cnt_q     <= db_cnt_d;
            lvl_q        <= lvl_d;
            lvl_dly_q    <= lvl_q;
            hold_q       <= hold_d;
            long_fired_q <= long_fired_d;
            press_q      <= rise;
            short_q      <= fall & ~long_fired_q;
            long_q       <= long_hit;
            ack_q        <= ack_d;
            ph_q         <= ph_d;
            slow_q       <= slow_d;
            fast_q       <= fast_d;
            grant_q      <= win_oh;
            led_q        <= led_d;
        end
    end

    assign led         = led_q;
    assign button_lvl  = lvl_q;
    assign press_pulse = press_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign led_grant   = grant_q;
endmodule

// File: tb/tb_debug_key_ctrl.sv
// tb_debug_key_ctrl: directed vectors and hand-timed sequences for debug_key_ctrl.
module tb_debug_key_ctrl;
    logic       clk = 1'b0, reset = 1'b1, button_raw = 1'b0;
    logic [3:0] led_req = '0;
    logic [7:0] led_mode = '0;
    logic       led, button_lvl, press_pulse, short_pulse, long_pulse;
    logic [3:0] led_grant;

    always #5 clk = ~clk;

    debug_key_ctrl #(
        .NUM_REQ(4), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20),
        .BLINK_HALF_CYCLES(8), .ACK_CYCLES(6)
    ) dut (
        .clk(clk), .reset(reset), .button_raw(button_raw), .led(led),
        .button_lvl(button_lvl), .press_pulse(press_pulse), .short_pulse(short_pulse),
        .long_pulse(long_pulse), .led_req(led_req), .led_mode(led_mode), .led_grant(led_grant)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] mode;
        logic [3:0] grant;
        logic       led;
    } vec_t;

    vec_t vt[9];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_press = 0, n_short = 0, n_long = 0, n_tog = 0;
    int press_at = -1, short_at = -1, long_at = -1, lvl_rise_at = -1, tog_at = -1;
    logic lvl_seen = 1'b0, led_seen = 1'b0;
    int t_ref = 0;
    logic lev_ref = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (press_pulse) begin n_press++; press_at = cyc; end
        if (short_pulse) begin n_short++; short_at = cyc; end
        if (long_pulse) begin n_long++; long_at = cyc; end
        if (button_lvl && !lvl_seen) lvl_rise_at = cyc;
        lvl_seen = button_lvl;
        if (led !== led_seen) begin n_tog++; tog_at = cyc; end
        led_seen = led;
    endtask

    task automatic wait_tog(output int t);
        int s;
        s = n_tog;
        for (int i = 0; i < 20 && n_tog == s; i++) tick();
        chk("led_toggle_seen", int'(n_tog != s), 1);
        t = tog_at;
    endtask

    // raw held for n cycles starting at t, then released and left to settle
    task automatic hold_raw(input int n, output int t);
        button_raw = 1'b1;
        t = cyc;
        repeat (n) tick();
        button_raw = 1'b0;
        repeat (30) tick();
    endtask

    function automatic int slow_model(input int c);
        return int'(lev_ref ^ (((c - t_ref) / 8) % 2 == 1));
    endfunction

    initial begin
        int t, p0, s0, l0, r, t1, t2, t3, ones;
        vt[0] = '{4'b0000, 8'b00_00_00_00, 4'b0000, 1'b0};
        vt[1] = '{4'b1000, 8'b01_00_00_00, 4'b1000, 1'b1};
        vt[2] = '{4'b1010, 8'b01_00_00_00, 4'b0010, 1'b0};
        vt[3] = '{4'b1000, 8'b01_00_00_00, 4'b1000, 1'b1};
        vt[4] = '{4'b1111, 8'b01_01_00_01, 4'b0001, 1'b1};
        vt[5] = '{4'b0110, 8'b01_01_00_01, 4'b0010, 1'b0};
        vt[6] = '{4'b0100, 8'b01_01_00_01, 4'b0100, 1'b1};
        vt[7] = '{4'b0000, 8'b01_01_01_01, 4'b0000, 1'b0};
        vt[8] = '{4'b0001, 8'b01_01_01_00, 4'b0001, 1'b0};

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", int'({led, button_lvl, press_pulse, short_pulse, long_pulse, led_grant}), 0);
        end
        reset = 1'b0;
        repeat (3) tick();

        p0 = n_press;
        button_raw = 1'b1; tick();
        button_raw = 1'b0; tick();
        button_raw = 1'b1; t = cyc;
        repeat (12) tick();
        chk("bounce_lvl_rise", lvl_rise_at, t + 6);
        chk("bounce_press_at", press_at, t + 7);
        chk("bounce_press_count", n_press - p0, 1);
        button_raw = 1'b0;
        repeat (30) tick();

        p0 = n_press; s0 = n_short; l0 = n_long;
        hold_raw(10, t);
        chk("short_press_count", n_press - p0, 1);
        chk("short_press_at", press_at, t + 7);
        chk("short_count", n_short - s0, 1);
        chk("short_at", short_at, t + 17);
        chk("short_no_long", n_long - l0, 0);

        s0 = n_short; l0 = n_long;
        hold_raw(20, t);
        chk("edge_short_at", short_at, t + 27);
        chk("edge_short_count", n_short - s0, 1);
        chk("edge_no_long", n_long - l0, 0);

        s0 = n_short; l0 = n_long;
        hold_raw(21, t);
        chk("edge_long_at", long_at, t + 27);
        chk("edge_long_count", n_long - l0, 1);
        chk("edge_no_short", n_short - s0, 0);

        p0 = n_press; s0 = n_short; l0 = n_long;
        hold_raw(40, t);
        chk("long_press_count", n_press - p0, 1);
        chk("long_after_press", long_at - press_at, 20);
        chk("long_count", n_long - l0, 1);
        chk("long_no_short", n_short - s0, 0);

        for (int i = 0; i < 9; i++) begin
            led_req = vt[i].req;
            led_mode = vt[i].mode;
            tick();
            chk($sformatf("arb_grant_%0d", i), int'(led_grant), int'(vt[i].grant));
            chk($sformatf("arb_led_%0d", i), int'(led), int'(vt[i].led));
        end

        led_req = 4'b0001;
        led_mode = 8'b00_00_00_10;
        repeat (2) tick();
        wait_tog(t1); wait_tog(t2); wait_tog(t3);
        chk("slow_period_a", t2 - t1, 8);
        chk("slow_period_b", t3 - t2, 8);
        t_ref = t3;
        lev_ref = led;

        button_raw = 1'b1;
        t = cyc;
        repeat (7) tick();
        chk("ack_press_at", press_at, t + 7);
        ones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (led) ones++;
        end
        chk("ack_forced_cycles", ones, 6);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("blink_resume_%0d", k), int'(led), slow_model(cyc));
        end
        button_raw = 1'b0;
        repeat (30) tick();

        led_mode = 8'b00_00_00_11;
        repeat (2) tick();
        wait_tog(t1); wait_tog(t2); wait_tog(t3);
        chk("fast_period_a", t2 - t1, 4);
        chk("fast_period_b", t3 - t2, 4);
        chk("fast_phase_base", (t2 - t_ref) % 4, 0);

        led_req = '0;
        led_mode = '0;
        l0 = n_long;
        s0 = n_short;
        button_raw = 1'b1;
        t = cyc;
        repeat (17) tick();
        chk("midrst_press_at", press_at, t + 7);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_outputs", int'({led, button_lvl, press_pulse, short_pulse, long_pulse, led_grant}), 0);
        end
        reset = 1'b0;
        r = cyc;
        repeat (32) tick();
        chk("midrst_lvl_rise", lvl_rise_at, r + 6);
        chk("midrst_press_at", press_at, r + 7);
        chk("midrst_long_at", long_at, r + 27);
        chk("midrst_long_count", n_long - l0, 1);
        button_raw = 1'b0;
        repeat (20) tick();
        chk("midrst_no_short", n_short - s0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
